// File: rtl/sid_pkg.sv
// Shared definitions for the SID register-write sequencer: bus widths,
// register offsets, command payload layout and FSM state encoding.
package sid_pkg;

  localparam int unsigned SID_ADDR_W = 5;
  localparam int unsigned SID_DATA_W = 8;
  localparam int unsigned SID_DLY_W  = 16;
  localparam int unsigned SID_CMD_W  = SID_ADDR_W + SID_DATA_W + SID_DLY_W;

  // Voice register offsets
  localparam logic [SID_ADDR_W-1:0] SID_REG_CTRL = 5'h04;
  localparam logic [SID_ADDR_W-1:0] SID_REG_AD   = 5'h05;
  localparam logic [SID_ADDR_W-1:0] SID_REG_SR   = 5'h06;

  // One queued register write plus the post-write delay in clkEn ticks
  typedef struct packed {
    logic [SID_ADDR_W-1:0] addr;
    logic [SID_DATA_W-1:0] data;
    logic [SID_DLY_W-1:0]  delay;
  } sid_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } sid_wr_state_e;

endpackage

// File: rtl/sid_cmd_fifo.sv
// Synchronous command FIFO with flush and occupancy output.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   flush         - empty the FIFO; overrides push and pop this cycle
//   push, wdata   - write request and payload (ignored when full)
//   pop           - read request (ignored when empty)
//   rdata         - head entry (valid while not empty)
//   level         - current occupancy
//   full, empty   - occupancy flags
module sid_cmd_fifo
  import sid_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LVL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  sid_cmd_t         wdata,
  input  logic             pop,
  output sid_cmd_t         rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sid_cmd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  // Fullness is judged on the registered level, so a same-cycle pop never makes room
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sid_wr_seq.sv
// SID register-write sequencer: queues host commands and replays them on the
// voice register bus, spacing writes by a per-command delay in clkEn ticks.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   clkEn                    - 1 MHz delay time-base strobe
//   iCmdValid/oCmdReady      - host command handshake
//   iCmdAddr/Data/Delay      - command payload
//   iFlush                   - drop queued commands and abort a pending delay
//   oWE/oAddr/oData          - registered register-bus write
//   oLevel                   - FIFO occupancy
//   oIdle                    - FSM idle and FIFO empty
module sid_wr_seq
  import sid_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LVL_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clkEn,
  input  logic                  iCmdValid,
  output logic                  oCmdReady,
  input  logic [SID_ADDR_W-1:0] iCmdAddr,
  input  logic [SID_DATA_W-1:0] iCmdData,
  input  logic [SID_DLY_W-1:0]  iCmdDelay,
  input  logic                  iFlush,
  output logic                  oWE,
  output logic [SID_ADDR_W-1:0] oAddr,
  output logic [SID_DATA_W-1:0] oData,
  output logic [LVL_W-1:0]      oLevel,
  output logic                  oIdle
);

  sid_wr_state_e         state;
  sid_wr_state_e         state_nxt;
  logic [SID_DLY_W-1:0]  dly;
  logic [SID_DLY_W-1:0]  dly_nxt;
  logic                  we_nxt;
  logic [SID_ADDR_W-1:0] addr_nxt;
  logic [SID_DATA_W-1:0] data_nxt;
  logic                  pop;
  logic                  push;
  logic                  full;
  logic                  empty;
  sid_cmd_t              wcmd;
  sid_cmd_t              head;

  assign oCmdReady = !full && !iFlush;
  assign push      = iCmdValid && oCmdReady;
  assign wcmd      = '{addr: iCmdAddr, data: iCmdData, delay: iCmdDelay};
  assign oIdle     = (state == ST_IDLE) && empty;

  sid_cmd_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (iFlush),
    .push  (push),
    .wdata (wcmd),
    .pop   (pop),
    .rdata (head),
    .level (oLevel),
    .full  (full),
    .empty (empty)
  );

  // State, delay counter and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      dly   <= '0;
      oWE   <= 1'b0;
      oAddr <= '0;
      oData <= '0;
    end else begin
      state <= state_nxt;
      dly   <= dly_nxt;
      oWE   <= we_nxt;
      oAddr <= addr_nxt;
      oData <= data_nxt;
    end
  end

  // Next-state: oWE is raised on entry to WRITE so it is high for the whole WRITE cycle
  always_comb begin
    state_nxt = state;
    dly_nxt   = dly;
    we_nxt    = 1'b0;
    addr_nxt  = oAddr;
    data_nxt  = oData;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && !iFlush) begin
          pop       = 1'b1;
          dly_nxt   = head.delay;
          addr_nxt  = head.addr;
          data_nxt  = head.data;
          we_nxt    = 1'b1;
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // clkEn seen here is deliberately not counted
        if (iFlush || (dly == '0)) begin
          dly_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (iFlush) begin
          dly_nxt   = '0;
          state_nxt = ST_IDLE;
        end else if (clkEn) begin
          dly_nxt = dly - SID_DLY_W'(1);
          if (dly == SID_DLY_W'(1)) state_nxt = ST_IDLE;
        end
      end
      default: begin
        dly_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sid_wr_seq.sv
// Self-checking bench for sid_wr_seq: vector table for single write and
// delay spacing, hand sequences for full, flush, reset and pointer wrap.
module tb_sid_wr_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        clkEn;
  logic        iCmdValid;
  logic        oCmdReady;
  logic [4:0]  iCmdAddr;
  logic [7:0]  iCmdData;
  logic [15:0] iCmdDelay;
  logic        iFlush;
  logic        oWE;
  logic [4:0]  oAddr;
  logic [7:0]  oData;
  logic [4:0]  oLevel;
  logic        oIdle;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sid_wr_seq #(.DEPTH(16), .LVL_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .clkEn     (clkEn),
    .iCmdValid (iCmdValid),
    .oCmdReady (oCmdReady),
    .iCmdAddr  (iCmdAddr),
    .iCmdData  (iCmdData),
    .iCmdDelay (iCmdDelay),
    .iFlush    (iFlush),
    .oWE       (oWE),
    .oAddr     (oAddr),
    .oData     (oData),
    .oLevel    (oLevel),
    .oIdle     (oIdle)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  addr;
    logic [7:0]  data;
    logic [15:0] dly;
    logic        clken;
    logic        e_ready;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [7:0]  e_data;
    logic [4:0]  e_level;
    logic        e_idle;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [7:0] d,
                       input logic [15:0] dl);
    iCmdValid = v;
    iCmdAddr  = a;
    iCmdData  = d;
    iCmdDelay = dl;
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] a, input logic [7:0] d,
                              input logic [15:0] dl, input logic ce, input logic er,
                              input logic ew, input logic [4:0] ea, input logic [7:0] ed,
                              input logic [4:0] el, input logic ei);
    vec_t r;
    r.valid = v; r.addr = a; r.data = d; r.dly = dl; r.clken = ce;
    r.e_ready = er; r.e_we = ew; r.e_addr = ea; r.e_data = ed;
    r.e_level = el; r.e_idle = ei;
    return r;
  endfunction

  // Pointer-wrap scoreboard
  logic [12:0] exp_q[$];
  logic        mon_en = 1'b0;
  int          observed = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (oLevel > 5'd16) chk("wrap_level_max", int'(oLevel), 16);
      if (oWE) begin
        if (exp_q.size() == 0) begin
          chk("wrap_unexpected_we", 1, 0);
        end else begin
          chk("wrap_order", int'({oAddr, oData}), int'(exp_q.pop_front()));
        end
        observed++;
      end
    end
  end

  vec_t vt[13];

  initial begin
    int cnt;
    int sent;
    int wes;
    logic v;

    // valid addr data dly clken | ready we addr data level idle
    vt[0]  = mk(1, 5'h05, 8'hA3, 16'd0, 0,  1, 0, 5'h00, 8'h00, 5'd1, 0);
    vt[1]  = mk(0, 5'h00, 8'h00, 16'd0, 0,  1, 1, 5'h05, 8'hA3, 5'd0, 0);
    vt[2]  = mk(0, 5'h00, 8'h00, 16'd0, 0,  1, 0, 5'h05, 8'hA3, 5'd0, 1);
    vt[3]  = mk(1, 5'h04, 8'h01, 16'd3, 0,  1, 0, 5'h05, 8'hA3, 5'd1, 0);
    vt[4]  = mk(1, 5'h04, 8'h00, 16'd0, 1,  1, 1, 5'h04, 8'h01, 5'd1, 0);
    vt[5]  = mk(0, 5'h00, 8'h00, 16'd0, 1,  1, 0, 5'h04, 8'h01, 5'd1, 0);
    vt[6]  = mk(0, 5'h00, 8'h00, 16'd0, 1,  1, 0, 5'h04, 8'h01, 5'd1, 0);
    vt[7]  = mk(0, 5'h00, 8'h00, 16'd0, 0,  1, 0, 5'h04, 8'h01, 5'd1, 0);
    vt[8]  = mk(0, 5'h00, 8'h00, 16'd0, 1,  1, 0, 5'h04, 8'h01, 5'd1, 0);
    vt[9]  = mk(0, 5'h00, 8'h00, 16'd0, 0,  1, 0, 5'h04, 8'h01, 5'd1, 0);
    vt[10] = mk(0, 5'h00, 8'h00, 16'd0, 1,  1, 0, 5'h04, 8'h01, 5'd1, 0);
    vt[11] = mk(0, 5'h00, 8'h00, 16'd0, 0,  1, 1, 5'h04, 8'h00, 5'd0, 0);
    vt[12] = mk(0, 5'h00, 8'h00, 16'd0, 0,  1, 0, 5'h04, 8'h00, 5'd0, 1);

    rst = 1'b1; clkEn = 1'b0; iFlush = 1'b0;
    drive(0, 5'h00, 8'h00, 16'd0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_we", int'(oWE), 0);
    chk("rst_addr", int'(oAddr), 0);
    chk("rst_data", int'(oData), 0);
    chk("rst_level", int'(oLevel), 0);
    chk("rst_idle", int'(oIdle), 1);
    chk("rst_ready", int'(oCmdReady), 1);

    // Single write then delay-3 spacing
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].valid, vt[i].addr, vt[i].data, vt[i].dly);
      clkEn = vt[i].clken;
      #1;
      chk($sformatf("v%0d_ready", i), int'(oCmdReady), int'(vt[i].e_ready));
      tick();
      chk($sformatf("v%0d_we", i), int'(oWE), int'(vt[i].e_we));
      chk($sformatf("v%0d_addr", i), int'(oAddr), int'(vt[i].e_addr));
      chk($sformatf("v%0d_data", i), int'(oData), int'(vt[i].e_data));
      chk($sformatf("v%0d_level", i), int'(oLevel), int'(vt[i].e_level));
      chk($sformatf("v%0d_idle", i), int'(oIdle), int'(vt[i].e_idle));
    end
    drive(0, 5'h00, 8'h00, 16'd0);
    clkEn = 1'b0;

    // Full: park the FSM in a long WAIT, then fill the FIFO
    drive(1, 5'h04, 8'h10, 16'd100);
    tick();
    drive(0, 5'h00, 8'h00, 16'd0);
    tick(); tick();
    for (int i = 0; i < 16; i++) begin
      drive(1, 5'h06, 8'(i), 16'd100);
      #1;
      chk($sformatf("fill%0d_ready", i), int'(oCmdReady), 1);
      tick();
      chk($sformatf("fill%0d_level", i), int'(oLevel), i + 1);
    end
    drive(1, 5'h06, 8'hEE, 16'd100);
    #1;
    chk("full_ready", int'(oCmdReady), 0);
    tick();
    chk("full_level_17th", int'(oLevel), 16);
    drive(0, 5'h00, 8'h00, 16'd0);
    clkEn = 1'b1;
    cnt = 0;
    while (!oWE && cnt < 300) begin
      tick();
      cnt++;
    end
    chk("full_wait_cycles", cnt, 101);
    chk("full_pop_addr", int'(oAddr), 6);
    chk("full_pop_data", int'(oData), 0);
    chk("full_pop_level", int'(oLevel), 15);
    clkEn = 1'b0;
    #1;
    chk("full_ready_after_pop", int'(oCmdReady), 1);

    // Flush during WAIT with commands queued; same-cycle push is refused
    tick();
    drive(1, 5'h07, 8'hBB, 16'd0);
    iFlush = 1'b1;
    #1;
    chk("flush_ready", int'(oCmdReady), 0);
    tick();
    iFlush = 1'b0;
    drive(0, 5'h00, 8'h00, 16'd0);
    chk("flush_level", int'(oLevel), 0);
    chk("flush_idle", int'(oIdle), 1);
    wes = 0;
    clkEn = 1'b1;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (oWE) wes++;
    end
    clkEn = 1'b0;
    chk("flush_no_we", wes, 0);
    chk("flush_level_after", int'(oLevel), 0);

    // Reset in the middle of WAIT
    drive(1, 5'h06, 8'h11, 16'd50);
    tick();
    drive(1, 5'h05, 8'h22, 16'd0);
    tick();
    drive(0, 5'h00, 8'h00, 16'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_we", int'(oWE), 0);
    chk("mrst_level", int'(oLevel), 0);
    chk("mrst_idle", int'(oIdle), 1);
    chk("mrst_addr", int'(oAddr), 0);
    drive(1, 5'h05, 8'h77, 16'd0);
    tick();
    drive(0, 5'h00, 8'h00, 16'd0);
    chk("mrst_lat1_we", int'(oWE), 0);
    tick();
    chk("mrst_lat2_we", int'(oWE), 1);
    chk("mrst_lat2_addr", int'(oAddr), 5);
    chk("mrst_lat2_data", int'(oData), 8'h77);
    tick();
    chk("mrst_idle_after", int'(oIdle), 1);

    // Pointer wrap: 40 delay-0 commands with random gaps
    mon_en = 1'b1;
    sent = 0;
    cnt = 0;
    while (sent < 40 && cnt < 1000) begin
      v = ($urandom_range(0, 2) != 0);
      drive(v, 5'(sent), 8'($urandom), 16'd0);
      #1;
      if (v && oCmdReady) begin
        exp_q.push_back({iCmdAddr, iCmdData});
        sent++;
      end
      tick();
      cnt++;
    end
    drive(0, 5'h00, 8'h00, 16'd0);
    chk("wrap_sent", sent, 40);
    cnt = 0;
    while (observed < 40 && cnt < 400) begin
      tick();
      cnt++;
    end
    tick(); tick();
    mon_en = 1'b0;
    chk("wrap_observed", observed, 40);
    chk("wrap_final_idle", int'(oIdle), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sid_wr_seq.md
SID_WR_SEQ -- requirements
Module: sid_wr_seq

Interface
REQ-001 The block SHALL take one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-002 Parameter DEPTH, default 16, SHALL set the command FIFO depth; it SHALL be a power of two, 2..256.
REQ-003 Parameter LVL_W, default 5, SHALL set the fill-level width, equal to log2(DEPTH)+1.
REQ-004 Port clk, input, 1 bit: master clock.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port clkEn, input, 1 bit: one-cycle strobe at 1 MHz, the delay time base.
REQ-007 Port iCmdValid, input, 1 bit: host command valid.
REQ-008 Port oCmdReady, output, 1 bit: the FIFO can accept a command this cycle.
REQ-009 Port iCmdAddr, input, 5 bits: SID register address to write.
REQ-010 Port iCmdData, input, 8 bits: SID register data.
REQ-011 Port iCmdDelay, input, 16 bits: clkEn ticks to wait after this write before the next write.
REQ-012 Port iFlush, input, 1 bit: discard all queued commands and abort any pending delay.
REQ-013 Port oWE, output, 1 bit: register-bus write strobe to SID voice blocks.
REQ-014 Port oAddr, output, 5 bits: register-bus address.
REQ-015 Port oData, output, 8 bits: register-bus data.
REQ-016 Port oLevel, output, LVL_W bits: current FIFO occupancy.
REQ-017 Port oIdle, output, 1 bit: high when the FSM is in IDLE and the FIFO is empty.

Function
REQ-018 A command SHALL be accepted on any rising edge where iCmdValid and oCmdReady are both high.
REQ-019 oCmdReady SHALL equal (oLevel != DEPTH) and (not iFlush), combinationally.
REQ-020 A push while full SHALL NOT occur; a same-cycle pop SHALL NOT free a slot for a same-cycle push.
REQ-021 The FIFO SHALL hold {addr, data, delay} (29 bits) per entry; pointers SHALL wrap modulo DEPTH.
REQ-022 The FSM SHALL have exactly three states:
- IDLE
- WRITE
- WAIT
REQ-023 IDLE behaviour: if the FIFO is non-empty, pop the head, load the delay counter with its delay, and go to WRITE; otherwise stay in IDLE.
REQ-024 WRITE behaviour: drive oWE=1 with the popped oAddr/oData for exactly one clk cycle, then go to IDLE if the delay is 0, else to WAIT.
REQ-025 WAIT behaviour: decrement the delay counter on each clkEn; when the counter is 1 and clkEn is high, go to IDLE.
REQ-026 Delay semantics: the next oWE SHALL NOT occur until N clkEn strobes have been seen after the WRITE cycle, for delay N.
REQ-027 oAddr and oData SHALL be registered and SHALL hold their last values while oWE=0.
REQ-028 Latency: with the FIFO empty and the FSM in IDLE, oWE SHALL be high in the second clk cycle after the accepting edge.
REQ-029 Back-to-back delay-0 commands SHALL produce oWE high every second clk cycle (WRITE then IDLE).
REQ-030 iFlush SHALL have priority over a same-cycle push and pop: the FIFO is emptied, oLevel becomes 0, and the FSM goes WAIT->IDLE.
REQ-031 A WRITE in progress SHALL complete its single oWE cycle when iFlush arrives, then go to IDLE regardless of delay.
REQ-032 A clkEn arriving during WRITE SHALL NOT count toward the delay.
REQ-033 oLevel SHALL be updated as follows:
- +1 on a push only
- -1 on a pop only
- unchanged on a simultaneous push and pop

Reset
REQ-034 On rst, the FSM SHALL enter IDLE.
REQ-035 On rst, the following SHALL be cleared to 0: FIFO pointers, oLevel, delay counter, oWE, oAddr and oData.
REQ-036 On rst, oIdle SHALL be 1 and oCmdReady SHALL be 1 in the first cycle after reset.
REQ-037 rst asserted mid-WAIT or mid-WRITE SHALL abort immediately; no oWE SHALL occur in the cycle following the reset edge.

Structure
REQ-038 The shared package sid_pkg SHALL hold:
- SID_ADDR_W=5 and SID_DATA_W=8
- the register offsets CTRL=0x04, AD=0x05, SR=0x06
- the FSM state enumeration
REQ-039 The FIFO SHALL be a separate sub-module, sid_cmd_fifo (synchronous, flush input, level output), instantiated once.

Verification
REQ-040 Single write: push {0x05, 0xA3, 0} into an idle block -> oWE=1 with oAddr=0x05 and oData=0xA3 exactly 2 clk after acceptance; oIdle returns to 1.
REQ-041 Delay: push {0x04, 0x01, 3} then {0x04, 0x00, 0} -> the second oWE occurs only after the 3rd clkEn following the first WRITE.
REQ-042 Full: with DEPTH=16, push 16 commands with delay 100 -> oLevel=16 and oCmdReady=0; a 17th valid is not accepted; after the first pop oCmdReady returns to 1.
REQ-043 Flush: during WAIT with 5 queued commands, pulse iFlush -> oLevel=0 and FSM in IDLE next cycle; no further oWE; a push in the flush cycle is not accepted.
REQ-044 Reset mid-operation: assert rst during WAIT -> oWE=0, oLevel=0 and oIdle=1 after one clk; a new command then issues with 2-cycle latency.
REQ-045 Pointer wrap: stream 40 delay-0 commands with random valid gaps -> oAddr/oData order matches push order exactly and oLevel never exceeds 16.
